// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-stage access path.
//   MW_*    : MEM_MemWidth encodings (2'b11 is handled as a word).
//   state_e : access FSM states.
package mem_pkg;

  localparam logic [1:0] MW_BYTE = 2'b00;
  localparam logic [1:0] MW_HALF = 2'b01;
  localparam logic [1:0] MW_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// load_extract: combinational load-lane select plus sign/zero extension.
//   rdata   in  32 : aligned word from memory
//   addr_lo in  2  : byte address bits [1:0]
//   width   in  2  : MW_BYTE / MW_HALF / word (anything else)
//   signext in  1  : 1 sign-extends narrow loads, 0 zero-extends
//   result  out 32 : extracted, extended load value
module load_extract
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  width,
  input  logic        signext,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      2'd3:    byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (width)
      MW_BYTE: result = {{24{signext & byte_lane[7]}}, byte_lane};
      MW_HALF: result = {{16{signext & half_lane[15]}}, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns a MEM-stage load/store into one handshaked,
// word-aligned data-memory bus transaction and returns the extended load
// data in MEM_dmOut. MEM_stall holds the pipeline while it is outstanding.
//   MEM_* inputs : address, store data, read/write, width, sign-extend
//   MEM_dmOut    : registered load result (0 after a bus timeout)
//   MEM_stall    : combinational pipeline freeze
//   MEM_addrErr  : combinational misaligned-access flag (no bus access)
//   MEM_busErr   : one-cycle registered timeout pulse
//   bus_*        : registered request side; bus_rdata/bus_ack return side
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] MEM_aluResult,
  input  logic [31:0] MEM_storeData,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [1:0]  MEM_MemWidth,
  input  logic        MEM_MemSignExt,
  output logic [31:0] MEM_dmOut,
  output logic        MEM_stall,
  output logic        MEM_addrErr,
  output logic        MEM_busErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  // Counter value seen on the last allowed BUSY cycle.
  localparam logic [7:0] CNT_LAST = 8'(BUS_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] dm_q, dm_d;
  logic        berr_q, berr_d;
  // Copies used for extraction so input changes during BUSY are ignored.
  logic [1:0]  width_q, width_d;
  logic [1:0]  alo_q, alo_d;
  logic        sext_q, sext_d;

  logic        access, misaligned, is_half, is_word;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, load_val;

  assign access     = MEM_MemRead | MEM_MemWrite;
  assign is_half    = (MEM_MemWidth == MW_HALF);
  assign is_word    = MEM_MemWidth[1];
  assign misaligned = (is_half & MEM_aluResult[0]) |
                      (is_word & (MEM_aluResult[1:0] != 2'b00));

  always_comb begin
    if (is_word) begin
      be_new    = 4'b1111;
      wdata_new = MEM_storeData;
    end else if (is_half) begin
      be_new    = MEM_aluResult[1] ? 4'b1100 : 4'b0011;
      wdata_new = {2{MEM_storeData[15:0]}};
    end else begin
      be_new    = 4'b0001 << MEM_aluResult[1:0];
      wdata_new = {4{MEM_storeData[7:0]}};
    end
  end

  load_extract u_extract (
    .rdata   (bus_rdata),
    .addr_lo (alo_q),
    .width   (width_q),
    .signext (sext_q),
    .result  (load_val)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    dm_d        = dm_q;
    berr_d      = 1'b0;
    width_d     = width_q;
    alo_d       = alo_q;
    sext_d      = sext_q;
    MEM_stall   = 1'b0;
    MEM_addrErr = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (misaligned) begin
            MEM_addrErr = 1'b1;
          end else begin
            MEM_stall = 1'b1;
            req_d     = 1'b1;
            we_d      = MEM_MemWrite;
            addr_d    = {MEM_aluResult[31:2], 2'b00};
            be_d      = be_new;
            wdata_d   = wdata_new;
            width_d   = MEM_MemWidth;
            alo_d     = MEM_aluResult[1:0];
            sext_d    = MEM_MemSignExt;
            cnt_d     = 8'd0;
            state_d   = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        MEM_stall = 1'b1;
        // Ack is tested first so it wins over a coinciding timeout.
        if (bus_ack) begin
          req_d   = 1'b0;
          if (!we_q) dm_d = load_val;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          dm_d    = 32'd0;
          berr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      dm_q    <= 32'd0;
      berr_q  <= 1'b0;
      width_q <= 2'd0;
      alo_q   <= 2'd0;
      sext_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      dm_q    <= dm_d;
      berr_q  <= berr_d;
      width_q <= width_d;
      alo_q   <= alo_d;
      sext_q  <= sext_d;
    end
  end

  assign MEM_dmOut  = dm_q;
  assign MEM_busErr = berr_q;
  assign bus_req    = req_q;
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_be     = be_q;
  assign bus_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed accesses, a transaction-level model
// producing per-cycle expectations, a negedge compare process, and literal
// checks on the hand-computed results.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] MEM_aluResult, MEM_storeData;
  logic        MEM_MemRead, MEM_MemWrite, MEM_MemSignExt;
  logic [1:0]  MEM_MemWidth;
  logic [31:0] MEM_dmOut;
  logic        MEM_stall, MEM_addrErr, MEM_busErr;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ack;

  always #5 clk = ~clk;

  mem_access_unit #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_aluResult(MEM_aluResult), .MEM_storeData(MEM_storeData),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_MemWidth(MEM_MemWidth), .MEM_MemSignExt(MEM_MemSignExt),
    .MEM_dmOut(MEM_dmOut), .MEM_stall(MEM_stall),
    .MEM_addrErr(MEM_addrErr), .MEM_busErr(MEM_busErr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  int checks = 0;
  int failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Transaction-level model state: what the bus side and result must hold.
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_dm;
  logic [3:0]  m_be;
  // Per-cycle expectations for the control outputs.
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_aerr, exp_berr, exp_req;

  function automatic logic [3:0] m_be_of(input logic [1:0] w, input logic [31:0] a);
    if (w == 2'b00) return 4'(1 << a[1:0]);
    if (w == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata_of(input logic [1:0] w, input logic [31:0] sd);
    if (w == 2'b00) return 32'(sd[7:0]) * 32'h01010101;
    if (w == 2'b01) return 32'(sd[15:0]) * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] w, input logic [31:0] a,
                                         input logic se, input logic [31:0] rd);
    logic [31:0] v;
    if (w == 2'b00) begin
      v = (rd >> (8 * a[1:0])) & 32'hFF;
      if (se && v[7]) v = v | 32'hFFFFFF00;
    end else if (w == 2'b01) begin
      v = (rd >> (16 * a[1])) & 32'hFFFF;
      if (se && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic bit m_mis(input logic [1:0] w, input logic [31:0] a);
    return (w == 2'b01 && a[0]) || (w[1] && a[1:0] != 2'b00);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check32("stall",   32'(MEM_stall),   32'(exp_stall));
      check32("addrErr", 32'(MEM_addrErr), 32'(exp_aerr));
      check32("busErr",  32'(MEM_busErr),  32'(exp_berr));
      check32("bus_req", 32'(bus_req),     32'(exp_req));
      check32("bus_we",  32'(bus_we),      32'(m_we));
      check32("bus_addr",  bus_addr,       m_addr);
      check32("bus_be",  32'(bus_be),      32'(m_be));
      check32("bus_wdata", bus_wdata,      m_wdata);
      check32("dmOut",     MEM_dmOut,      m_dm);
    end
  end

  int stall_cnt = 0, req_cnt = 0, berr_cnt = 0;
  always @(negedge clk) begin
    if (MEM_stall)  stall_cnt = stall_cnt + 1;
    if (bus_req)    req_cnt = req_cnt + 1;
    if (MEM_busErr) berr_cnt = berr_cnt + 1;
  end

  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_we;

  task automatic set_idle_exp();
    exp_stall = 1'b0; exp_aerr = 1'b0; exp_berr = 1'b0; exp_req = 1'b0;
  endtask

  // Entered at posedge+1 with the unit idle. ack_at: BUSY cycle (1-based)
  // that sees bus_ack; anything beyond TO means no ack.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] w,
                            input logic se, input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rdata, input int ack_at, input bit flip_se);
    bit timed_out;
    MEM_MemRead = rd; MEM_MemWrite = wr; MEM_MemWidth = w;
    MEM_MemSignExt = se; MEM_aluResult = a; MEM_storeData = sd;
    set_idle_exp();
    chk_en = 1'b1;
    if (m_mis(w, a)) begin
      exp_aerr = 1'b1;
      @(posedge clk); #1;
      MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
      exp_aerr = 1'b0;
      return;
    end
    exp_stall = 1'b1;
    @(posedge clk); #1;
    m_we = wr; m_addr = {a[31:2], 2'b00}; m_be = m_be_of(w, a); m_wdata = m_wdata_of(w, sd);
    exp_req = 1'b1;
    last_addr = bus_addr; last_be = bus_be; last_wdata = bus_wdata; last_we = bus_we;
    if (flip_se) MEM_MemSignExt = ~se;
    timed_out = 1'b0;
    for (int k = 1; k <= TO + 1; k++) begin
      if (k == ack_at) begin bus_ack = 1'b1; bus_rdata = rdata; end
      else bus_rdata = ~rdata;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (k == ack_at) break;
      if (k == TO) begin timed_out = 1'b1; break; end
    end
    exp_req = 1'b0; exp_stall = 1'b0; exp_berr = timed_out;
    if (timed_out) m_dm = 32'd0;
    else if (rd) m_dm = m_load(w, a, se, rdata);
    @(posedge clk); #1;
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_MemSignExt = 1'b0;
    exp_berr = 1'b0;
  endtask

  int s0, r0, b0;

  initial begin
    MEM_aluResult = 32'd0; MEM_storeData = 32'd0; MEM_MemRead = 1'b0;
    MEM_MemWrite = 1'b0; MEM_MemWidth = 2'b00; MEM_MemSignExt = 1'b0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0; m_dm = 32'd0; m_be = 4'd0;
    set_idle_exp();

    #1;
    check32("rst_req", 32'(bus_req), 32'd0);
    check32("rst_dm", MEM_dmOut, 32'd0);
    check32("rst_stall", 32'(MEM_stall), 32'd0);
    check32("rst_addr", bus_addr, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Word load, ack on 2nd BUSY cycle: three stall cycles.
    s0 = stall_cnt;
    run_access(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0);
    check32("wl_dm", MEM_dmOut, 32'hDEADBEEF);
    check32("wl_addr", last_addr, 32'h100);
    check32("wl_be", 32'(last_be), 32'hF);
    check32("wl_stall_cycles", 32'(stall_cnt - s0), 32'd3);

    // Signed byte load from lane 3; sign-extend flipped mid-flight.
    run_access(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80FFFFFF, 1, 1);
    check32("sb_dm", MEM_dmOut, 32'hFFFFFF80);
    check32("sb_be", 32'(last_be), 32'h8);
    run_access(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80FFFFFF, 1, 0);
    check32("ub_dm", MEM_dmOut, 32'h00000080);

    // Half store: replicated data, result untouched.
    run_access(0, 1, 2'b01, 0, 32'h206, 32'h1234ABCD, 32'h0, 3, 0);
    check32("hs_we", 32'(last_we), 32'd1);
    check32("hs_addr", last_addr, 32'h204);
    check32("hs_be", 32'(last_be), 32'hC);
    check32("hs_wdata", last_wdata, 32'hABCDABCD);
    check32("hs_dm", MEM_dmOut, 32'h00000080);

    // Misaligned word and half: no bus activity.
    r0 = req_cnt;
    run_access(1, 0, 2'b10, 0, 32'h101, 32'h0, 32'h0, 1, 0);
    run_access(1, 0, 2'b01, 1, 32'h203, 32'h0, 32'h0, 1, 0);
    @(posedge clk); #1;
    check32("mis_no_req", 32'(req_cnt - r0), 32'd0);

    // Signed half from upper lane, ack coincides with the last BUSY cycle.
    run_access(1, 0, 2'b01, 1, 32'h102, 32'h0, 32'h80017FFF, TO, 0);
    check32("sh_dm", MEM_dmOut, 32'hFFFF8001);

    // Byte store to lane 1.
    run_access(0, 1, 2'b00, 0, 32'h101, 32'hCAFE005A, 32'h0, 1, 0);
    check32("bs_be", 32'(last_be), 32'h2);
    check32("bs_wdata", last_wdata, 32'h5A5A5A5A);

    // Timeout: req held TO cycles, single error pulse, result cleared.
    r0 = req_cnt; b0 = berr_cnt;
    run_access(1, 0, 2'b10, 0, 32'h400, 32'h0, 32'h11111111, TO + 5, 0);
    check32("to_req_cycles", 32'(req_cnt - r0), 32'(TO));
    check32("to_berr_pulses", 32'(berr_cnt - b0), 32'd1);
    check32("to_dm", MEM_dmOut, 32'd0);

    // Width 11 behaves as word.
    run_access(1, 0, 2'b11, 1, 32'h300, 32'h0, 32'h12345678, 1, 0);
    check32("w11_dm", MEM_dmOut, 32'h12345678);

    // Reset during BUSY, then a late ack is ignored.
    chk_en = 1'b0;
    MEM_MemRead = 1'b1; MEM_MemWidth = 2'b10; MEM_aluResult = 32'h10;
    @(posedge clk); #1;
    check32("rm_req_up", 32'(bus_req), 32'd1);
    #2; rst_n = 1'b0; MEM_MemRead = 1'b0;
    #1;
    check32("rm_req", 32'(bus_req), 32'd0);
    check32("rm_stall", 32'(MEM_stall), 32'd0);
    check32("rm_dm", MEM_dmOut, 32'd0);
    check32("rm_addr", bus_addr, 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5;
    @(posedge clk); #1; rst_n = 1'b1;
    m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0; m_dm = 32'd0; m_be = 4'd0;
    set_idle_exp(); chk_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; bus_ack = 1'b0;

    // Recovery after reset.
    run_access(1, 0, 2'b00, 1, 32'h501, 32'h0, 32'h0000FE00, 2, 0);
    check32("rec_dm", MEM_dmOut, 32'hFFFFFFFE);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access unit between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns a load or store from the MEM stage into a handshaked, word-aligned transaction on the data-memory bus. For loads it lane-extracts and sign- or zero-extends the returned data into `MEM_dmOut`, which MEM/WB captures. It holds `MEM_stall` high while a transaction is outstanding, so the pipeline freezes until `MEM_dmOut` is valid.

## Interface
- `BUS_TIMEOUT`, default 255: maximum cycles in BUSY waiting for `bus_ack` before the access is aborted. Legal range is 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `MEM_aluResult` in 32: effective byte address.
- `MEM_storeData` in 32: store data; the low byte or half is used for narrow stores.
- `MEM_MemRead` in 1: load request.
- `MEM_MemWrite` in 1: store request. Never asserted together with `MEM_MemRead`.
- `MEM_MemWidth` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `MEM_MemSignExt` in 1: 1 sign-extends narrow loads, 0 zero-extends them.
- `MEM_dmOut` out 32: registered load result.
- `MEM_stall` out 1: freeze PC, IF/ID, ID/EX and EX/MEM, and hold MEM/WB.
- `MEM_addrErr` out 1: misaligned access, combinational.
- `MEM_busErr` out 1: one-cycle timeout pulse, registered.
- `bus_req` out 1: transaction request, registered.
- `bus_we` out 1: 1 for write, registered.
- `bus_addr` out 32: `{addr[31:2],2'b00}`, registered.
- `bus_be` out 4: byte enables, registered.
- `bus_wdata` out 32: lane-replicated write data, registered.
- `bus_rdata` in 32: read data, valid with `bus_ack`.
- `bus_ack` in 1: completes the transaction; ignored when `bus_req` is 0.

## Operation
- FSM states are IDLE, BUSY and DONE.
- **Access detection**
  - access = `MEM_MemRead | MEM_MemWrite`.
  - misaligned = (half & addr[0]) | (word & addr[1:0] != 0).
- **IDLE**
  - access & !misaligned: `MEM_stall`=1 combinationally. At the next edge, latch `bus_*`, set `bus_req`=1 and go to BUSY.
  - access & misaligned: `MEM_addrErr`=1, no bus transaction, `MEM_stall`=0, `MEM_dmOut` unchanged.
- **BUSY**
  - `MEM_stall`=1. `bus_*` outputs are held stable and the timeout counter increments each cycle.
  - On `bus_ack`: drop `bus_req` at the edge. For a read, load `MEM_dmOut` with the extracted and extended data; for a write, `MEM_dmOut` is unchanged. Go to DONE.
  - On counter reaching `BUS_TIMEOUT` without ack: drop `bus_req`, set `MEM_dmOut`=0, pulse `MEM_busErr` for the DONE cycle, go to DONE.
  - If `bus_ack` and the timeout coincide, ack wins.
- **DONE**
  - `MEM_stall`=0, so the pipeline advances and MEM/WB captures `MEM_dmOut`.
  - Unconditionally go to IDLE. The next instruction's access is evaluated in IDLE only.
- **Byte enables** (little-endian)
  - Byte: `bus_be` = 0001 shifted left by addr[1:0].
  - Half: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - Word: 1111.
- **Write data**
  - Byte: `{4{sd[7:0]}}`.
  - Half: `{2{sd[15:0]}}`.
  - Word: sd.
- **Read extraction**
  - Byte: take the lane selected by addr[1:0].
  - Half: take the lane selected by addr[1].
  - Extend to 32 bits per `MEM_MemSignExt`, using the latched copy of width, sign and addr[1:0].
- Width, sign and address low bits are latched on IDLE→BUSY, so later input changes have no effect.

## Timing
- **Reset values:** state=IDLE, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0, `MEM_dmOut`=0, `MEM_busErr`=0, timeout counter=0.
- **Reset mid-transaction:** all of the above apply immediately and asynchronously; the pending ack is dropped.
- **Latency:** an access with ack on the first BUSY cycle takes 3 cycles (IDLE, BUSY, DONE). Each extra wait cycle adds one.
- **Stall:** `MEM_stall` is combinational, so the hazard unit sees it in the same cycle the access appears.
- **Back-to-back accesses:** the second access sees IDLE one cycle after DONE. No overlap, no pipelining of bus transactions.
- **Timeout:** aborts after exactly `BUS_TIMEOUT` BUSY cycles. The counter clears on entry to BUSY.

## Structure
- Shared package `mem_pkg`:
  - width codes `MW_BYTE`=2'b00, `MW_HALF`=2'b01, `MW_WORD`=2'b10;
  - FSM state encodings `S_IDLE`, `S_BUSY`, `S_DONE`.
- One sub-module, `load_extract`: combinational lane select plus extension (`rdata`, `addr_lo`, `width`, `signext` → 32-bit result). It is reused by the future cache path.
- Byte-enable and write-replication logic stays inline.

## Test plan
- **Word load:** addr 0x100, ack 2 cycles after req, `bus_rdata`=0xDEADBEEF → `bus_addr`=0x100, `bus_be`=1111, stall for 3 cycles, `MEM_dmOut`=0xDEADBEEF in DONE.
- **Signed byte load:** addr 0x103, signext=1, rdata=0x80FFFFFF → `bus_be`=1000, `MEM_dmOut`=0xFFFFFF80. Repeat with signext=0 → 0x00000080.
- **Half store:** addr 0x206, sd=0x1234ABCD → `bus_we`=1, `bus_addr`=0x204, `bus_be`=1100, `bus_wdata`=0xABCDABCD, `MEM_dmOut` unchanged.
- **Misaligned word load:** addr 0x101 → `MEM_addrErr`=1, `bus_req` never rises, `MEM_stall`=0.
- **Timeout:** `BUS_TIMEOUT`=4, no ack → `bus_req` high for 4 cycles, then `MEM_busErr` pulses for one cycle, `MEM_dmOut`=0, `MEM_stall` drops.
- **Reset mid-transaction:** `rst_n` low during BUSY → `bus_req`, `MEM_stall` (state IDLE) and `MEM_dmOut` go to 0 without a clock edge. A later ack is ignored.
